// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch / execute-phase-0 / execute-phase-1 with
// memory-handshake stalls, strobe gating for the decoder and a sticky fetch timeout.
module cpu_sequencer #(
  parameter int IR_WIDTH  = 16,
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [IR_WIDTH-1:0]  mem_rdata,
  input  logic                 mem_ready,
  input  logic                 dmem_busy,
  input  logic                 dec_ns,
  input  logic                 dec_wr,
  input  logic                 dec_memwrite,
  input  logic                 dec_irl,
  output logic                 fetch_req,
  output logic [IR_WIDTH-1:0]  ir,
  output logic                 state,
  output logic                 wr_en,
  output logic                 mem_we,
  output logic                 pc_en,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {IDLE, FETCH, EX0, EX1, FAULT} seq_state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t      cur_state;
  seq_state_t      nxt_state;
  logic [TW-1:0]   wait_cnt;
  logic            timeout_hit;
  logic            ir_load;
  logic            unused_irl;

  // IR_L is a decoder consistency signal observed only outside the datapath.
  assign unused_irl  = dec_irl;
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    fetch_req = 1'b0;
    wr_en     = 1'b0;
    mem_we    = 1'b0;
    pc_en     = 1'b0;
    ir_load   = 1'b0;
    case (cur_state)
      IDLE: begin
        if (run) nxt_state = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        // A ready arriving on the final allowed wait cycle still completes the fetch.
        if (mem_ready) begin
          ir_load   = 1'b1;
          nxt_state = EX0;
        end else if (timeout_hit) begin
          nxt_state = FAULT;
        end
      end
      EX0: begin
        if (!dmem_busy) begin
          wr_en  = dec_wr;
          mem_we = dec_memwrite;
          if (dec_ns) begin
            nxt_state = EX1;
          end else begin
            pc_en     = 1'b1;
            nxt_state = run ? FETCH : IDLE;
          end
        end
      end
      EX1: begin
        if (!dmem_busy) begin
          wr_en     = dec_wr;
          mem_we    = dec_memwrite;
          pc_en     = 1'b1;
          nxt_state = run ? FETCH : IDLE;
        end
      end
      FAULT: begin
        nxt_state = FAULT;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // Counts consecutive not-ready FETCH cycles; cleared everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   wait_cnt <= '0;
    else if (cur_state == FETCH && !mem_ready) wait_cnt <= wait_cnt + TW'(1);
    else                                       wait_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ir <= '0;
    else if (ir_load) ir <= mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        retired <= '0;
    else if (pc_en) retired <= retired + CNT_WIDTH'(1);
  end

  assign state = (cur_state == EX1);
  assign fault = (cur_state == FAULT);

endmodule
